// File: rtl/seq_booth_r4_mul.sv
// Iterative radix-4 Booth multiplier: one Booth digit per clock, valid/ready on both sides,
// per-transaction signed/unsigned selection, exact 2*width-bit product held until taken.
module seq_booth_r4_mul #(
   parameter int width = 7
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [width-1:0]     A,
   input  logic [width-1:0]     B,
   input  logic                 signed_mode,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*width-1:0]   P,
   output logic                 busy
);

   localparam int NDIG  = (width + 2) / 2;
   localparam int ACC_W = 2 * width + 2;
   localparam int BW    = 2 * NDIG + 1;
   localparam int CW    = $clog2(NDIG + 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [CW-1:0] CNT_LAST = CW'(NDIG - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   logic [1:0]         state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic [ACC_W-1:0]   a_q, a_d;
   logic [BW-1:0]      b_q, b_d;
   logic [2*width-1:0] p_q, p_d;
   logic               in_ready_q, in_ready_d;
   logic               out_valid_q, out_valid_d;
   logic               busy_q, busy_d;

   logic               sign_a_s, sign_b_s;
   logic [ACC_W-1:0]   a_ext_s, a2_s, term_s, sum_s;
   logic [BW-1:0]      b_ext_s;

   assign sign_a_s = signed_mode & A[width-1];
   assign sign_b_s = signed_mode & B[width-1];
   assign a_ext_s  = {{(ACC_W - width){sign_a_s}}, A};
   assign b_ext_s  = {{(BW - 1 - width){sign_b_s}}, B, 1'b0};

   // a_q is pre-shifted by 4^k each digit, so the term is already at the digit's weight.
   assign a2_s  = {a_q[ACC_W-2:0], 1'b0};
   assign sum_s = acc_q + term_s;

   // Booth digit decode of the current LSB-first triplet
   always_comb begin
      term_s = {ACC_W{1'b0}};
      case (b_q[2:0])
         3'b001, 3'b010: term_s = a_q;
         3'b011:         term_s = a2_s;
         3'b100:         term_s = {ACC_W{1'b0}} - a2_s;
         3'b101, 3'b110: term_s = {ACC_W{1'b0}} - a_q;
         default:        term_s = {ACC_W{1'b0}};
      endcase
   end

   // Next-state logic for the IDLE/CALC/DONE controller and datapath
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      acc_d       = acc_q;
      a_d         = a_q;
      b_d         = b_q;
      p_d         = p_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      busy_d      = busy_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               state_d    = S_CALC;
               a_d        = a_ext_s;
               b_d        = b_ext_s;
               acc_d      = {ACC_W{1'b0}};
               cnt_d      = {CW{1'b0}};
               in_ready_d = 1'b0;
               busy_d     = 1'b1;
            end else begin
               state_d    = S_IDLE;
            end
         end
         S_CALC: begin
            acc_d = sum_s;
            a_d   = {a_q[ACC_W-3:0], 2'b00};
            b_d   = {{2{b_q[BW-1]}}, b_q[BW-1:2]};
            cnt_d = cnt_q + CNT_ONE;
            if (cnt_q == CNT_LAST) begin
               state_d     = S_DONE;
               p_d         = sum_s[2*width-1:0];
               out_valid_d = 1'b1;
            end else begin
               state_d     = S_CALC;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_d     = S_IDLE;
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               busy_d      = 1'b0;
            end else begin
               state_d     = S_DONE;
            end
         end
         default: begin
            state_d     = S_IDLE;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
            busy_d      = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= {CW{1'b0}};
         acc_q       <= {ACC_W{1'b0}};
         a_q         <= {ACC_W{1'b0}};
         b_q         <= {BW{1'b0}};
         p_q         <= {(2*width){1'b0}};
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
         a_q         <= a_d;
         b_q         <= b_d;
         p_q         <= p_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign P         = p_q;

endmodule

// File: tb/tb_seq_booth_r4_mul.sv
// Self-checking bench for seq_booth_r4_mul at width=7 and width=8, directed cases plus a
// randomized sweep against an arithmetic reference product.
module tb_seq_booth_r4_mul;

   logic        clk;
   logic        rst;
   logic [1:0]  in_valid, out_ready, in_ready, out_valid, busy;
   logic [7:0]  a, b;
   logic        smode;
   logic [13:0] p7;
   logic [15:0] p8;
   int          sel;
   int          n_checks;
   int          n_fail;

   logic        cur_ready, cur_ov, cur_busy;
   logic [63:0] cur_p;

   seq_booth_r4_mul #(.width(7)) dut7 (
      .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .A(a[6:0]), .B(b[6:0]), .signed_mode(smode), .out_valid(out_valid[0]),
      .out_ready(out_ready[0]), .P(p7), .busy(busy[0])
   );

   seq_booth_r4_mul #(.width(8)) dut8 (
      .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .A(a), .B(b), .signed_mode(smode), .out_valid(out_valid[1]),
      .out_ready(out_ready[1]), .P(p8), .busy(busy[1])
   );

   assign cur_ready = (sel == 1) ? in_ready[1]  : in_ready[0];
   assign cur_ov    = (sel == 1) ? out_valid[1] : out_valid[0];
   assign cur_busy  = (sel == 1) ? busy[1]      : busy[0];
   assign cur_p     = (sel == 1) ? {48'd0, p8}  : {50'd0, p7};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: interpret operands per mode as integers, multiply, keep 2*w bits.
   function automatic logic [63:0] golden(input logic [63:0] av, input logic [63:0] bv,
                                          input logic m, input int w);
      longint x, y, prod;
      longint mask_w;
      mask_w = (longint'(1) << w) - 1;
      x = longint'(av) & mask_w;
      y = longint'(bv) & mask_w;
      if (m && ((x >> (w - 1)) & 1) == 1) x = x - (longint'(1) << w);
      if (m && ((y >> (w - 1)) & 1) == 1) y = y - (longint'(1) << w);
      prod = x * y;
      return 64'(prod & ((longint'(1) << (2 * w)) - 1));
   endfunction

   task automatic run_txn(input logic [7:0] ta, input logic [7:0] tb, input logic tm,
                          input int hold, input logic [63:0] exp, input string tag);
      int w, nd, n;
      w  = (sel == 1) ? 8 : 7;
      nd = (w + 2) / 2;
      a = ta;
      b = tb;
      smode = tm;
      in_valid[sel] = 1'b1;
      n = 0;
      while (!cur_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      check_eq({tag, "_ready"}, {63'd0, cur_ready}, 64'd1);
      @(posedge clk); #1;
      in_valid[sel] = 1'b0;
      a = 8'($urandom);
      b = 8'($urandom);
      smode = 1'($urandom);
      check_eq({tag, "_busy"}, {63'd0, cur_busy}, 64'd1);
      n = 0;
      while (!cur_ov && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      check_eq({tag, "_latency"}, 64'(n), 64'(nd));
      check_eq({tag, "_P"}, cur_p, exp);
      repeat (hold) begin
         in_valid[sel] = 1'($urandom);
         a = 8'($urandom);
         b = 8'($urandom);
         @(posedge clk); #1;
         check_eq({tag, "_hold_P"}, cur_p, exp);
         check_eq({tag, "_hold_state"}, {61'd0, cur_ov, cur_ready, cur_busy}, 64'b101);
      end
      in_valid[sel] = 1'b0;
      out_ready[sel] = 1'b1;
      @(posedge clk); #1;
      out_ready[sel] = 1'b0;
      check_eq({tag, "_handoff"}, {61'd0, cur_ov, cur_ready, cur_busy}, 64'b010);
   endtask

   initial begin
      n_checks = 0;
      n_fail = 0;
      sel = 0;
      rst = 1'b1;
      in_valid = 2'b00;
      out_ready = 2'b00;
      a = 8'd0;
      b = 8'd0;
      smode = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      for (int s = 0; s < 2; s++) begin
         sel = s;
         #0;
         check_eq("reset_flags", {61'd0, cur_ov, cur_ready, cur_busy}, 64'b010);
         check_eq("reset_P", cur_p, 64'd0);
      end
      sel = 0;

      run_txn(8'h40, 8'h40, 1'b1, 0, 64'h1000, "s_neg64_sq");
      run_txn(8'h40, 8'h3F, 1'b1, 1, 64'h3040, "s_neg64x63");
      run_txn(8'h7F, 8'h7F, 1'b1, 0, 64'h0001, "s_m1xm1");
      run_txn(8'h7F, 8'h7F, 1'b0, 0, 64'h3F01, "u_max_sq");
      run_txn(8'h00, 8'h55, 1'b0, 0, 64'h0000, "u_zero");
      run_txn(8'h40, 8'h3F, 1'b1, 6, 64'h3040, "backpressure");

      // Abort in the middle of CALC, then confirm a clean restart.
      a = 8'h3F;
      b = 8'h3F;
      smode = 1'b0;
      in_valid[0] = 1'b1;
      @(posedge clk); #1;
      in_valid[0] = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check_eq("abort_flags", {61'd0, cur_ov, cur_ready, cur_busy}, 64'b010);
      check_eq("abort_P", cur_p, 64'd0);
      run_txn(8'h3F, 8'h3F, 1'b0, 0, 64'h0F81, "after_abort");

      sel = 1;
      run_txn(8'h80, 8'h80, 1'b1, 0, 64'h4000, "w8_s_min_sq");
      run_txn(8'hFF, 8'hFF, 1'b0, 0, 64'hFE01, "w8_u_max_sq");

      for (int s = 0; s < 2; s++) begin
         for (int m = 0; m < 2; m++) begin
            sel = s;
            for (int t = 0; t < 1000; t++) begin
               logic [7:0] ra, rb;
               int w;
               w  = (s == 1) ? 8 : 7;
               ra = 8'($urandom_range(0, (1 << w) - 1));
               rb = 8'($urandom_range(0, (1 << w) - 1));
               if (t == 0) begin
                  ra = (s == 1) ? 8'h80 : 8'h40;
                  rb = ra;
               end
               run_txn(ra, rb, 1'(m), $urandom_range(0, 2),
                       golden({56'd0, ra}, {56'd0, rb}, 1'(m), w), "rand");
               repeat ($urandom_range(0, 2)) @(posedge clk);
               #1;
            end
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
